// File: rtl/crc_scrub_pkg.sv
// Shared state encoding and counter width for the CRC memory scrubber.
package crc_scrub_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    CHECK,
    WRBACK,
    NEXT,
    DONE
  } scrub_state_t;

endpackage

// File: rtl/crc_scrub_sat_cnt.sv
// Saturating event counter with synchronous clear, used for the scrub error tallies.
module crc_scrub_sat_cnt
  import crc_scrub_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/crc_scrubber.sv
// Background memory scrubber: walks every address, counts ECC events, optionally rewrites
// corrected words. Define CRC_SCRUB_WRITEBACK_EN to enable writeback of corrected data.
module crc_scrubber
  import crc_scrub_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int RD_LATENCY = 2,
  parameter int CONTINUOUS = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  host_req,
  output logic                  mem_own,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic                  err_detected,
  input  logic                  err_corrected,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           corr_cnt,
  output logic [15:0]           uncorr_cnt,
  output logic                  uncorr_flag,
  output logic [ADDR_WIDTH-1:0] uncorr_addr
);

  localparam logic [1:0] WAIT_LAST = 2'(RD_LATENCY >= 2 ? RD_LATENCY - 2 : 0);

  scrub_state_t          state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic [DATA_WIDTH-1:0] data_p1;
  logic [1:0]            wait_cnt;
  logic                  start_pend, pend_nxt;
  logic                  addr_clr, addr_inc, cnt_clr;
  logic                  corr_inc, uncorr_inc, wait_inc, sample;
  logic                  addr_last;

  assign addr_last = (addr_p0 == {ADDR_WIDTH{1'b1}});

  always_comb begin
    state_nxt  = state;
    pend_nxt   = start_pend;
    addr_clr   = 1'b0;
    addr_inc   = 1'b0;
    cnt_clr    = 1'b0;
    corr_inc   = 1'b0;
    uncorr_inc = 1'b0;
    wait_inc   = 1'b0;
    sample     = 1'b0;
    unique case (state)
      IDLE: begin
        // A start seen while the host owns the port is remembered until it lets go.
        if (start && !stop) begin
          addr_clr = 1'b1;
          cnt_clr  = 1'b1;
          if (host_req) begin
            pend_nxt = 1'b1;
          end else begin
            pend_nxt  = 1'b0;
            state_nxt = READ;
          end
        end else if (stop) begin
          pend_nxt = 1'b0;
        end else if (start_pend && !host_req) begin
          pend_nxt  = 1'b0;
          state_nxt = READ;
        end
      end
      READ: begin
        state_nxt = (RD_LATENCY == 1) ? CHECK : WAIT;
      end
      WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          state_nxt = CHECK;
        end else begin
          wait_inc = 1'b1;
        end
      end
      CHECK: begin
        sample = 1'b1;
        if (err_detected && err_corrected) begin
          corr_inc = 1'b1;
`ifdef CRC_SCRUB_WRITEBACK_EN
          state_nxt = WRBACK;
`else
          state_nxt = NEXT;
`endif
        end else if (err_detected) begin
          uncorr_inc = 1'b1;
          state_nxt  = NEXT;
        end else begin
          state_nxt = NEXT;
        end
      end
      WRBACK: begin
        state_nxt = NEXT;
      end
      NEXT: begin
        // The address only advances once the host has released the port.
        if (stop) begin
          state_nxt = IDLE;
        end else if (addr_last && (CONTINUOUS == 0)) begin
          state_nxt = DONE;
        end else if (!host_req) begin
          addr_inc  = 1'b1;
          state_nxt = READ;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // stage p0: control state, scan address and uncorrectable log
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      start_pend  <= 1'b0;
      addr_p0     <= '0;
      wait_cnt    <= '0;
      uncorr_flag <= 1'b0;
      uncorr_addr <= '0;
    end else begin
      state      <= state_nxt;
      start_pend <= pend_nxt;
      if (addr_clr) begin
        addr_p0 <= '0;
      end else if (addr_inc) begin
        addr_p0 <= addr_p0 + ADDR_WIDTH'(1);
      end
      if (state != WAIT) begin
        wait_cnt <= '0;
      end else if (wait_inc) begin
        wait_cnt <= wait_cnt + 2'd1;
      end
      if (cnt_clr) begin
        uncorr_flag <= 1'b0;
      end else if (uncorr_inc) begin
        uncorr_flag <= 1'b1;
        uncorr_addr <= addr_p0;
      end
    end
  end

  // stage p1: corrected word captured in CHECK for a possible writeback
  always_ff @(posedge clk) begin
    if (sample) begin
      data_p1 <= mem_data_out;
    end
  end

  crc_scrub_sat_cnt u_corr_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (corr_inc),
    .cnt (corr_cnt)
  );

  crc_scrub_sat_cnt u_uncorr_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (uncorr_inc),
    .cnt (uncorr_cnt)
  );

  assign mem_own     = state inside {READ, WAIT, CHECK, WRBACK};
  assign mem_addr    = addr_p0;
  assign mem_data_in = (state == WRBACK) ? data_p1 : '0;
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);

`ifdef CRC_SCRUB_WRITEBACK_EN
  assign mem_wr = (state == WRBACK);
`else
  assign mem_wr = 1'b0;
`endif

endmodule

// File: doc/crc_scrubber.md
CRC_SCRUBBER -- requirements
Module: crc_scrubber

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the memory word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8; memory depth is 2**ADDR_WIDTH.
REQ-003 SHALL have parameter RD_LATENCY, default 2 (range 1..4), the cycles from address presented to mem_data_out/err flags valid.
REQ-004 SHALL have parameter CONTINUOUS, default 0; 1 = wrap to address 0 after the last address instead of finishing.
REQ-005 SHALL use one clock and a synchronous, active-high reset: clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-006 SHALL have: start  in  1  pulse, begin a scrub pass; stop  in  1  abort at the next address boundary; host_req  in  1  host needs the memory port.
REQ-007 SHALL have: mem_own  out  1  scrubber drives the memory port; mem_wr  out  1  write strobe; mem_addr  out  ADDR_WIDTH  address; mem_data_in  out  DATA_WIDTH  write data.
REQ-008 SHALL have: mem_data_out  in  DATA_WIDTH  corrected read data; err_detected  in  1; err_corrected  in  1.
REQ-009 SHALL have: busy  out  1; done  out  1  one-cycle pulse; corr_cnt  out  16; uncorr_cnt  out  16; uncorr_flag  out  1  sticky; uncorr_addr  out  ADDR_WIDTH  last uncorrectable address.

Function
REQ-010 SHALL implement states IDLE, READ, WAIT, CHECK, WRBACK, NEXT, DONE.
REQ-011 IDLE: start=1 and stop=0 SHALL clear address, corr_cnt, uncorr_cnt, uncorr_flag and go to READ; start with stop=1 SHALL stay in IDLE; start while not IDLE SHALL be ignored.
REQ-012 READ SHALL be entered only when host_req=0; otherwise the FSM SHALL hold (IDLE->READ or NEXT->READ deferred) with mem_own=0.
REQ-013 READ SHALL last one cycle with mem_own=1, mem_wr=0, mem_addr=current address.
REQ-014 WAIT SHALL last RD_LATENCY-1 cycles (skipped when RD_LATENCY=1); CHECK SHALL sample mem_data_out and flags exactly RD_LATENCY cycles after the READ cycle.
REQ-015 CHECK, no error: go to NEXT with no write.
REQ-016 CHECK, err_detected=1 and err_corrected=1: corr_cnt SHALL increment; go to WRBACK (see REQ-024).
REQ-017 CHECK, err_detected=1 and err_corrected=0: uncorr_cnt SHALL increment, uncorr_flag SHALL set, uncorr_addr SHALL load current address, no write; go to NEXT.
REQ-018 WRBACK SHALL last one cycle: mem_own=1, mem_wr=1, mem_addr=current address, mem_data_in=sampled data.
REQ-019 mem_own SHALL be 1 from READ through WRBACK inclusive; the sequence SHALL be atomic regardless of host_req.
REQ-020 NEXT: stop=1 SHALL go to IDLE without done; last address with CONTINUOUS=0 SHALL go to DONE; otherwise address increments (wrapping to 0) and go to READ per REQ-012.
REQ-021 DONE SHALL assert done for one cycle then enter IDLE; busy SHALL be 1 in every state except IDLE.
REQ-022 Counters SHALL saturate at 16'hFFFF; mem_wr, mem_own SHALL be 0 outside their states.

Reset
REQ-023 rst=1 at a clock edge SHALL force IDLE and all outputs and counters to 0 on that edge, discarding any pending writeback, in any state.

Configuration
REQ-024 Macro CRC_SCRUB_WRITEBACK_EN: defined -> correctable errors take WRBACK; undefined -> CHECK goes directly to NEXT, mem_wr is constant 0, corr_cnt still counts.

Structure
REQ-025 Package crc_scrub_pkg SHALL hold the state enum typedef and constant CNT_W=16.
REQ-026 Sub-module crc_scrub_sat_cnt (CNT_W-bit saturating counter with sync clear) SHALL be instantiated for corr_cnt and uncorr_cnt.

Verification (DATA_WIDTH=8, ADDR_WIDTH=4, RD_LATENCY=2, CONTINUOUS=0)
REQ-027 Clean memory, start at cycle 0 -> address k read at cycle 1+4k, no mem_wr, done at cycle 65, counters 0.
REQ-028 Single-bit flip at addr 5, macro defined -> exactly one mem_wr, mem_addr=5, corrected data; corr_cnt=1.
REQ-029 Double flip at addr 9 -> no mem_wr; uncorr_flag=1, uncorr_addr=9, uncorr_cnt=1.
REQ-030 host_req high 10 cycles while in NEXT after addr 3 -> mem_own=0 for those 10 cycles; addr 4 read the cycle after host_req drops.
REQ-031 rst during WRBACK at addr 5 -> next cycle mem_wr=0, busy=0, counters 0; later start rescans from addr 0.
REQ-032 Macro undefined, flip at addr 5 -> no mem_wr ever, corr_cnt=1, done at cycle 65.
